// File: rtl/pio_poll_sequencer.sv
// Purpose : periodically reads a 4-bit PIO input and debounces it. Accepted changes are posted as events.
// Latency : one sample every POLL_PERIOD clocks; an accepted change shows on the edge that ends its SAMPLE cycle.
// Backpr. : event_valid is held until event_ready. A newer event overwrites the pending one and sets overrun.
//
// Ports:
//   clk, reset_n            clock, asynchronous active-low reset
//   enable                  level; 1 runs polling, 0 halts it (stable value and pending event are kept)
//   pio_address             address to the PIO slave: 2'b00 while reading, 2'b11 otherwise
//   pio_readdata            registered PIO read data; only [3:0] is used
//   sample_strobe           one-cycle pulse during each SAMPLE cycle
//   stable_in               debounced input value
//   event_valid/_data/_ready  change-event handshake
//   overrun, clear_overrun  sticky lost-event flag and its clear pulse

module pio_poll_sequencer #(
  parameter int POLL_PERIOD = 1000,
  parameter int DEBOUNCE_N  = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  output logic [1:0]  pio_address,
  input  logic [31:0] pio_readdata,
  output logic        sample_strobe,
  output logic [3:0]  stable_in,
  output logic        event_valid,
  output logic [3:0]  event_data,
  input  logic        event_ready,
  output logic        overrun,
  input  logic        clear_overrun
);

  // WAIT counts down from this value to 0, which takes POLL_PERIOD-2 cycles.
  localparam logic [15:0] LP_WAIT_LOAD = 16'(POLL_PERIOD - 3);
  localparam logic [3:0]  LP_DB_N      = 4'(DEBOUNCE_N);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ADDR, S_SAMPLE} state_t;

  state_t      r_state;
  logic [15:0] r_int_cnt;
  logic [3:0]  r_db_cnt;
  logic [3:0]  r_cand;

  logic [3:0]  w_sample;
  logic [3:0]  w_cand_next;
  logic [3:0]  w_cnt_next;
  logic        w_fire;
  logic        w_unused_rd;

  assign w_unused_rd = ^pio_readdata[31:4];

  // Debounce decision for the current read data. It takes effect only on the edge that ends SAMPLE.
  // The candidate doubles as the previous differing sample. Any sample equal to stable_in clears the count.
  // The count therefore restarts from 1 whenever the candidate changes.
  always_comb begin
    w_sample    = pio_readdata[3:0];
    w_cand_next = r_cand;
    w_cnt_next  = r_db_cnt;
    if (w_sample == stable_in) begin
      w_cnt_next = 4'd0;
    end else if (w_sample == r_cand) begin
      w_cnt_next = (r_db_cnt >= LP_DB_N) ? LP_DB_N : r_db_cnt + 4'd1;
    end else begin
      w_cand_next = w_sample;
      w_cnt_next  = 4'd1;
    end
    w_fire = (r_state == S_SAMPLE) && enable && (w_cnt_next == LP_DB_N);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= S_IDLE;
      r_int_cnt     <= 16'd0;
      r_db_cnt      <= 4'd0;
      r_cand        <= 4'd0;
      pio_address   <= 2'b11;
      sample_strobe <= 1'b0;
      stable_in     <= 4'd0;
      event_valid   <= 1'b0;
      event_data    <= 4'd0;
      overrun       <= 1'b0;
    end else begin
      sample_strobe <= 1'b0;

      if (!enable) begin
        r_state     <= S_IDLE;
        r_int_cnt   <= 16'd0;
        r_db_cnt    <= 4'd0;
        pio_address <= 2'b11;
      end else begin
        case (r_state)
          S_IDLE: begin
            r_state     <= S_WAIT;
            r_int_cnt   <= LP_WAIT_LOAD;
            pio_address <= 2'b11;
          end
          S_WAIT: begin
            if (r_int_cnt == 16'd0) begin
              r_state     <= S_ADDR;
              pio_address <= 2'b00;
            end else begin
              r_int_cnt <= r_int_cnt - 16'd1;
            end
          end
          S_ADDR: begin
            // The slave registers the read during ADDR, so the data is valid throughout SAMPLE.
            r_state       <= S_SAMPLE;
            sample_strobe <= 1'b1;
          end
          S_SAMPLE: begin
            r_state     <= S_WAIT;
            r_int_cnt   <= LP_WAIT_LOAD;
            pio_address <= 2'b11;
            r_cand      <= w_cand_next;
            if (w_fire) begin
              stable_in <= w_cand_next;
              r_db_cnt  <= 4'd0;
            end else begin
              r_db_cnt  <= w_cnt_next;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end

      // The event handshake also runs while polling is halted.
      // When a new event and a clear arrive on the same edge, the overrun set wins.
      if (w_fire) begin
        event_valid <= 1'b1;
        event_data  <= w_cand_next;
        if (event_valid && !event_ready) begin
          overrun <= 1'b1;
        end else if (clear_overrun) begin
          overrun <= 1'b0;
        end
      end else begin
        if (event_valid && event_ready) begin
          event_valid <= 1'b0;
        end
        if (clear_overrun) begin
          overrun <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_pio_poll_sequencer.sv
module tb_pio_poll_sequencer;

  localparam int P = 8;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        enable;
  logic [1:0]  pio_address;
  logic [31:0] pio_readdata;
  logic        sample_strobe;
  logic [3:0]  stable_in;
  logic        event_valid;
  logic [3:0]  event_data;
  logic        event_ready;
  logic        overrun;
  logic        clear_overrun;

  pio_poll_sequencer #(.POLL_PERIOD(P), .DEBOUNCE_N(3)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable),
    .pio_address(pio_address), .pio_readdata(pio_readdata),
    .sample_strobe(sample_strobe), .stable_in(stable_in),
    .event_valid(event_valid), .event_data(event_data),
    .event_ready(event_ready), .overrun(overrun),
    .clear_overrun(clear_overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] st;
    logic       ev;
    logic [3:0] ed;
    logic       ov;
    int         id;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int en_cyc = 0;
  int epoch = 0;
  int sample_id = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: watches strobes and checks address/timing, then checks the post-sample state one cycle later.
  logic [1:0] addr_h1 = 2'b11, addr_h2 = 2'b11;
  int   last_cyc = 0, last_epoch = -1;
  bit   post_pending = 0;
  exp_t cur;

  always @(negedge clk) begin
    if (reset_n && post_pending) begin
      post_pending = 0;
      check($sformatf("post_sample_%0d", cur.id),
            {22'd0, stable_in, event_valid, event_data, overrun},
            {22'd0, cur.st, cur.ev, cur.ed, cur.ov});
      check($sformatf("addr_after_sample_%0d", cur.id), {30'd0, pio_address}, 32'd3);
    end
    if (reset_n && sample_strobe) begin
      check("addr_sequence", {26'd0, addr_h2, addr_h1, pio_address}, 32'b11_00_00);
      if (last_epoch == epoch) check("sample_period", cyc - last_cyc, P);
      else                     check("first_sample_delay", cyc - en_cyc, P);
      last_cyc = cyc;
      last_epoch = epoch;
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_sample actual=strobe required=none (t=%0t)", $time);
      end else begin
        cur = q.pop_front();
        post_pending = 1;
      end
    end
    addr_h2 = addr_h1;
    addr_h1 = pio_address;
  end

  task automatic do_sample(input logic [3:0] d, input logic rdy, input logic clr,
                           input logic [3:0] es, input logic ev, input logic [3:0] ed, input logic ov);
    exp_t e;
    bit   seen = 0;
    pio_readdata = {28'd0, d};
    e.st = es; e.ev = ev; e.ed = ed; e.ov = ov; e.id = sample_id++;
    q.push_back(e);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (sample_strobe) begin seen = 1; break; end
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL sample_timeout actual=none required=strobe id=%0d", e.id);
    end
    event_ready = rdy;
    clear_overrun = clr;
    @(posedge clk); #1;
    event_ready = 1'b0;
    clear_overrun = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_addr"},   {30'd0, pio_address}, 32'd3);
    check({tag, "_strobe"}, {31'd0, sample_strobe}, 32'd0);
    check({tag, "_outs"},   {22'd0, stable_in, event_valid, event_data, overrun}, 32'd0);
  endtask

  initial begin
    reset_n = 1'b1; enable = 1'b0; pio_readdata = 32'd0;
    event_ready = 1'b0; clear_overrun = 1'b0;
    #2 reset_n = 1'b0;
    #1 check_reset_vals("reset");
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1; enable = 1'b1; en_cyc = cyc; epoch++;

    // Steady 5: event on third sample
    do_sample(4'h5, 0, 0, 4'h0, 0, 4'h0, 0);
    do_sample(4'h5, 0, 0, 4'h0, 0, 4'h0, 0);
    do_sample(4'h5, 0, 0, 4'h5, 1, 4'h5, 0);
    // Accept
    do_sample(4'h5, 1, 0, 4'h5, 0, 4'h5, 0);
    // One-sample glitch to A
    do_sample(4'hA, 0, 0, 4'h5, 0, 4'h5, 0);
    do_sample(4'h5, 0, 0, 4'h5, 0, 4'h5, 0);
    do_sample(4'h5, 0, 0, 4'h5, 0, 4'h5, 0);
    // Overrun: 5->A->3 without acceptance, then clear
    do_sample(4'hA, 0, 0, 4'h5, 0, 4'h5, 0);
    do_sample(4'hA, 0, 0, 4'h5, 0, 4'h5, 0);
    do_sample(4'hA, 0, 0, 4'hA, 1, 4'hA, 0);
    do_sample(4'h3, 0, 0, 4'hA, 1, 4'hA, 0);
    do_sample(4'h3, 0, 0, 4'hA, 1, 4'hA, 0);
    do_sample(4'h3, 0, 0, 4'h3, 1, 4'h3, 1);
    do_sample(4'h3, 0, 1, 4'h3, 1, 4'h3, 0);
    // Same-edge accept and new event
    do_sample(4'h5, 0, 0, 4'h3, 1, 4'h3, 0);
    do_sample(4'h5, 0, 0, 4'h3, 1, 4'h3, 0);
    do_sample(4'h5, 1, 0, 4'h5, 1, 4'h5, 0);
    do_sample(4'h5, 1, 0, 4'h5, 0, 4'h5, 0);
    // Overrun set wins over a simultaneous clear
    do_sample(4'h9, 0, 0, 4'h5, 0, 4'h5, 0);
    do_sample(4'h9, 0, 0, 4'h5, 0, 4'h5, 0);
    do_sample(4'h9, 0, 0, 4'h9, 1, 4'h9, 0);
    do_sample(4'h2, 0, 0, 4'h9, 1, 4'h9, 0);
    do_sample(4'h2, 0, 0, 4'h9, 1, 4'h9, 0);
    do_sample(4'h2, 0, 1, 4'h2, 1, 4'h2, 1);
    do_sample(4'h2, 0, 1, 4'h2, 1, 4'h2, 0);
    do_sample(4'h2, 1, 0, 4'h2, 0, 4'h2, 0);
    // Disable after 2 of 3 samples; re-enable needs 3 fresh samples
    do_sample(4'h7, 0, 0, 4'h2, 0, 4'h2, 0);
    do_sample(4'h7, 0, 0, 4'h2, 0, 4'h2, 0);
    enable = 1'b0; epoch++;
    repeat (5) @(posedge clk);
    #1 check("disabled_state", {25'd0, pio_address, stable_in, event_valid}, {25'd0, 2'b11, 4'h2, 1'b0});
    check("disabled_no_strobe", {31'd0, sample_strobe}, 32'd0);
    enable = 1'b1; en_cyc = cyc; epoch++;
    do_sample(4'h7, 0, 0, 4'h2, 0, 4'h2, 0);
    do_sample(4'h7, 0, 0, 4'h2, 0, 4'h2, 0);
    do_sample(4'h7, 0, 0, 4'h7, 1, 4'h7, 0);
    // Reset mid-WAIT with an event pending
    repeat (2) @(posedge clk);
    #2 reset_n = 1'b0; epoch++;
    #1 check_reset_vals("midreset");
    @(posedge clk);
    #1 reset_n = 1'b1; en_cyc = cyc; epoch++;
    do_sample(4'h4, 0, 0, 4'h0, 0, 4'h0, 0);
    do_sample(4'h4, 0, 0, 4'h0, 0, 4'h0, 0);
    do_sample(4'h4, 0, 0, 4'h4, 1, 4'h4, 0);

    repeat (3) @(negedge clk);
    check("queue_drained", q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pio_poll_sequencer.md
PIO_POLL_SEQUENCER -- requirements
Module: pio_poll_sequencer

Interface
REQ-001 Parameter POLL_PERIOD, default 1000: clocks between successive PIO samples; legal range 4..65535.
REQ-002 Parameter DEBOUNCE_N, default 4: consecutive identical differing samples needed to accept a new value; legal range 1..15.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 enable  input  1  level; 1 = polling runs, 0 = polling halted.
REQ-006 pio_address  output  2  address to the 4-bit input PIO slave.
REQ-007 pio_readdata  input  32  registered PIO read data; only bits [3:0] are used.
REQ-008 sample_strobe  output  1  one-cycle pulse per captured sample.
REQ-009 stable_in  output  4  debounced input value.
REQ-010 event_valid  output  1  change event pending.
REQ-011 event_data  output  4  new stable value carried by the pending event.
REQ-012 event_ready  input  1  consumer accepts the event when event_valid=1 and event_ready=1 on the same edge.
REQ-013 overrun  output  1  sticky flag: an unaccepted event was overwritten.
REQ-014 clear_overrun  input  1  pulse; clears overrun.

Function
REQ-015 FSM states: IDLE, WAIT, ADDR, SAMPLE.
REQ-016 IDLE: when enable=1, go to WAIT and load the interval counter.
REQ-017 Interval timing: WAIT lasts POLL_PERIOD-2 cycles, ADDR lasts 1, SAMPLE lasts 1; SAMPLE returns to WAIT, so SAMPLE recurs exactly every POLL_PERIOD clocks.
REQ-018 pio_address is 2'b00 in ADDR and SAMPLE, and 2'b11 in every other state.
REQ-019 SAMPLE captures pio_readdata[3:0] (one-cycle PIO read latency) and asserts sample_strobe for that cycle only.
REQ-020 Debounce, evaluated at SAMPLE:
  - sample == stable_in: debounce count cleared.
  - sample differs and equals the previous sample: count increments, saturating at DEBOUNCE_N.
  - sample differs from both: candidate := sample, count := 1.
REQ-021 When the count reaches DEBOUNCE_N, the following happen on the edge after SAMPLE, and the count clears:
  - stable_in := candidate;
  - event_data := candidate;
  - event_valid := 1.
REQ-022 With DEBOUNCE_N=1, a single differing sample updates stable_in and posts an event.
REQ-023 event_valid stays high until accepted; on acceptance with no new event, event_valid falls on the next edge.
REQ-024 New event while event_valid=1 and not accepted: event_data is overwritten by the newest value, event_valid stays 1, overrun is set.
REQ-025 Acceptance and new event on the same edge: the new event is loaded, event_valid stays 1, overrun is unchanged.
REQ-026 clear_overrun on the same edge as an overrun-setting event: the set wins.
REQ-027 enable falling to 0 in any state:
  - next state is IDLE;
  - interval and debounce counters clear;
  - stable_in and any pending event are retained.
REQ-028 Re-enable: the first SAMPLE occurs POLL_PERIOD-1 cycles after the IDLE->WAIT transition.
REQ-029 Interval counter is 16 bits; the debounce count is 4 bits with saturation (no wrap).

Reset
REQ-030 reset_n low asynchronously forces the following values; the first edge with reset_n high is an ordinary edge:
  - state = IDLE;
  - pio_address = 2'b11;
  - sample_strobe = 0;
  - stable_in = 0;
  - event_valid = 0;
  - event_data = 0;
  - overrun = 0;
  - all counters and the candidate = 0.
REQ-031 Reset asserted mid-interval or mid-debounce discards the partial count; a pending event is lost without setting overrun.

Verification
REQ-032 POLL_PERIOD=8, DEBOUNCE_N=3; enable=1, PIO in=4'h5 steady -> sample_strobe every 8 clocks; pio_address=0 in ADDR and SAMPLE only; on the 3rd sample: stable_in=5, event_data=5, event_valid=1.
REQ-033 Glitch: stable=5, in=4'hA for one sample then 5 -> no event, stable_in stays 5.
REQ-034 Overrun: event_ready=0; two successive accepted changes 5->A->3 -> event_data=3, overrun=1; clear_overrun pulse -> overrun=0, event_valid stays 1.
REQ-035 Same-edge accept: event_ready=1 on the edge that posts a new event -> event_valid stays 1 with the new data, overrun=0.
REQ-036 enable=0 after 2 of 3 debounce samples, then re-enable -> 3 fresh samples are needed before the event.
REQ-037 reset_n pulsed low mid-WAIT with event_valid=1 -> all outputs at reset values immediately; polling restarts from IDLE.
